// File: rtl/status_cond_unit.sv
// -----------------------------------------------------------------------------
// status_cond_unit
//
// Status register and condition-check stage that sits around the EXE-stage ALU
// of the 32-bit ARM pipeline.
//   * Latches the ALU {N,Z,C,V} bits when a flag-setting instruction leaves EXE.
//   * Returns the registered carry to the ALU for ADC/SBC.
//   * Evaluates the ARM condition field of the instruction in ID, optionally
//     forwarding flags that are being committed in the same cycle.
//   * Keeps a sticky overflow bit and a wrapping flag-commit counter.
//
// Ports
//   clk         pipeline clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   status_in   ALU status {N,Z,C,V} (N = bit 3, V = bit 0)
//   s_en        EXE instruction sets flags (S bit, CMP/TST/...)
//   exe_valid   EXE slot holds a real, non-flushed instruction
//   freeze      pipeline stall; blocks any commit
//   clr_q       clear sticky overflow
//   cond        condition field [31:28] of the instruction in ID
//   status_q    registered {N,Z,C,V}
//   c_out       registered carry, feeds the ALU carry input
//   cond_pass   ID instruction's condition is satisfied
//   sticky_v    a committed V=1 has been seen since the last clear
//   commit_cnt  number of flag commits, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module status_cond_unit #(
  parameter int CNT_W  = 8,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       status_in,
  input  logic             s_en,
  input  logic             exe_valid,
  input  logic             freeze,
  input  logic             clr_q,
  input  logic [3:0]       cond,
  output logic [3:0]       status_q,
  output logic             c_out,
  output logic             cond_pass,
  output logic             sticky_v,
  output logic [CNT_W-1:0] commit_cnt
);

  logic             commit;
  logic [3:0]       status_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             sticky_reg;
  logic             sticky_next;
  logic [3:0]       eff_flags;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic [6:0]       cond_base;
  logic [15:0]      cond_vec;

  // A stall wins over everything; a flushed slot never commits.
  assign commit = s_en & exe_valid & ~freeze;

  assign cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};

  // Setting wins over clearing when both happen in the same cycle.
  assign sticky_next = (sticky_reg & ~clr_q) | (commit & status_in[0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_reg <= 4'b0000;
      cnt_reg    <= '0;
      sticky_reg <= 1'b0;
    end else begin
      if (commit) begin
        status_reg <= status_in;
        cnt_reg    <= cnt_next;
      end
      sticky_reg <= sticky_next;
    end
  end

  // Flags seen by the condition check. With forwarding, a commit in this
  // cycle is visible to ID without waiting for the register.
  generate
    if (BYPASS) begin : g_bypass
      assign eff_flags = commit ? status_in : status_reg;
    end else begin : g_no_bypass
      assign eff_flags = status_reg;
    end
  endgenerate

  assign flag_n = eff_flags[3];
  assign flag_z = eff_flags[2];
  assign flag_c = eff_flags[1];
  assign flag_v = eff_flags[0];

  // ARM condition codes come in complementary pairs: the odd code is the
  // inverse of the even code below it. Only the even ones are built here.
  assign cond_base[0] = flag_z;                          // EQ
  assign cond_base[1] = flag_c;                          // CS
  assign cond_base[2] = flag_n;                          // MI
  assign cond_base[3] = flag_v;                          // VS
  assign cond_base[4] = flag_c & ~flag_z;                // HI
  assign cond_base[5] = ~(flag_n ^ flag_v);              // GE
  assign cond_base[6] = ~flag_z & ~(flag_n ^ flag_v);    // GT

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_cond_pair
      assign cond_vec[2*gi]   = cond_base[gi];
      assign cond_vec[2*gi+1] = ~cond_base[gi];
    end
  endgenerate

  assign cond_vec[14] = 1'b1;  // AL
  assign cond_vec[15] = 1'b0;  // NV

  // Held low during reset so nothing in ID executes on undefined flags.
  assign cond_pass  = rst_n & cond_vec[cond];

  assign status_q   = status_reg;
  assign c_out      = status_reg[1];
  assign sticky_v   = sticky_reg;
  assign commit_cnt = cnt_reg;

endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Status register and condition-check stage wrapped around the EXE-stage ALU of the 32-bit ARM pipeline.
- Latches the ALU's {N,Z,C,V} status bits when an S-suffixed instruction retires out of EXE.
- Feeds the registered carry back to the ALU `c` input for ADC/SBC.
- Evaluates the 4-bit ARM condition field of the instruction in ID against the flags, forwarding flags that are being committed in the same cycle.

Parameters:
- CNT_W, 8, width of flag-commit counter (debug/perf), wraps modulo 2^CNT_W
- BYPASS, 1, 1 = cond check sees same-cycle committing flags; 0 = registered flags only

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- status_in  input  4  ALU status bits {N,Z,C,V}, N at bit 3, V at bit 0
- s_en  input  1  EXE instruction has S bit set (flag-setting, incl. CMP/TST)
- exe_valid  input  1  EXE slot holds a real, non-flushed instruction
- freeze  input  1  pipeline stall from hazard unit; blocks commit
- clr_q  input  1  clear sticky overflow
- cond  input  4  condition field [31:28] of instruction in ID
- status_q  output  4  registered {N,Z,C,V}
- c_out  output  1  equals status_q[1]; drives ALU `c`
- cond_pass  output  1  ID instruction's condition satisfied
- sticky_v  output  1  set when any committed V = 1 since last clear
- commit_cnt  output  CNT_W  number of flag commits, wraps

Behaviour:
- Commit, internal: commit = s_en & exe_valid & ~freeze.
- Reset: on a rising edge with rst_n=0, status_q=4'b0000, sticky_v=0, commit_cnt=0. While rst_n=0, cond_pass=0 (combinationally forced).
- Status register, per edge:
  - commit=1: status_q <= status_in; commit_cnt <= commit_cnt+1, wrapping from 2^CNT_W-1 to 0.
  - Otherwise status_q and commit_cnt hold.
  - freeze has priority over s_en/exe_valid.
- Latency: flags written in the EXE cycle are visible on status_q/c_out the next cycle. ADC/SBC in the following EXE cycle sees the new carry with no bubble.
- Sticky V:
  - Next value = (sticky_v & ~clr_q) | (commit & status_in[0]).
  - Same-cycle clr_q and commit with V=1 leaves sticky_v=1 (set wins).
- Effective flags {N,Z,C,V} for the condition check:
  - BYPASS=1 and commit=1: status_in.
  - Otherwise: status_q.
- cond_pass is combinational from cond and the effective flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111 NV: 0
- Flushed EXE slot (exe_valid=0) never commits and never forwards, even if s_en=1.
- Frozen cycle: no forwarding. cond_pass uses status_q; ID is stalled, so it re-evaluates once freeze drops.
- No X propagation: all outputs are defined for every input combination after the first reset edge.

Test Plan:
- Reset: rst_n=0 for 2 edges with status_in=4'b1111, s_en=1, exe_valid=1 -> status_q=0, commit_cnt=0, sticky_v=0, cond_pass=0. Release with cond=1110 -> cond_pass=1.
- Commit/hold: status_in=4'b0110 (Z,C), s_en=1, exe_valid=1 for 1 cycle, then s_en=0 and status_in=4'b1001 -> status_q=4'b0110 and c_out=1 held; commit_cnt=1.
- Bypass: status_q=0; in the same cycle commit status_in=4'b0100 with cond=0000 -> cond_pass=1 before the edge. With BYPASS=0 -> cond_pass=0 in that cycle, 1 after the edge.
- Freeze/flush: freeze=1, s_en=1, exe_valid=1, status_in=4'b1000 -> status_q unchanged, cnt unchanged. Repeat with freeze=0, exe_valid=0 -> unchanged.
- Condition sweep: for each status_q in {0000,1000,0100,0010,0001,1001,0110}, sweep cond 0..15 -> cond_pass matches the table. Examples: GE with N=1,V=1 -> 1; LE with N=1,V=0 -> 1; NV -> 0.
- Counter wrap and sticky:
  - 256 commits with CNT_W=8 -> commit_cnt=0.
  - Commit V=1 with clr_q=1 in the same cycle -> sticky_v=1.
  - clr_q alone next cycle -> sticky_v=0.
